decode_stage: RTL and testbench
===============================

DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 Parameter pc_bit_size, default 32, width of PC buses.
REQ-002 clk  input  1  single clock; all state updates on posedge clk.
REQ-003 rst  input  1  reset; asynchronous, active-high.
REQ-004 stall  input  1  downstream register-fetch stage cannot accept; hold all outputs.
REQ-005 flush  input  1  branch/redirect; discard current instruction.
REQ-006 instin  input  8  ZPU opcode byte from fetch.
REQ-007 instvalid  input  1  instin/pcin/nextpcin valid this cycle.
REQ-008 pcin, nextpcin  input  pc_bit_size  PC of instin and PC of the following byte.
REQ-009 stallout  output  1  stall to fetch, equal to stall (combinational).
REQ-010 decodedinst  output reg  6  `exe_* code per zpupkg.v.
REQ-011 spstateadr  output reg  2  operand-B source: `stay_sp_source / `inc_sp_source / `offset_sp_source / `tos_sp_source.
REQ-012 spstate  output reg  2  SP update: `stay_sp / `inc_sp / `dec_sp / `tos_sp.
REQ-013 instofset  output reg  5  stack-offset field; instvalue output reg 7, immediate field.
REQ-014 pcout, nextpcout  output reg  pc_bit_size  registered pcin/nextpcin; instructiondbgout output reg 8, registered raw instin.

Function
REQ-015 One-cycle latency: instruction presented with instvalid=1 while stall=0 and flush=0 SHALL appear on outputs the next cycle.
REQ-016 stall=1 and flush=0: every output register and the IM flag SHALL hold.
REQ-017 flush=1 (priority over stall): decodedinst<=`exe_nop, spstate<=`stay_sp, spstateadr<=`stay_sp_source, IM flag<=0; other outputs hold.
REQ-018 instvalid=0, stall=0, flush=0: decodedinst<=`exe_nop, spstate/spstateadr<=stay; IM flag unchanged.
REQ-019 Decode table (decodedinst, spstate, spstateadr):
  1xxxxxxx IM, flag=0: `exe_im, dec_sp, stay_src; flag=1: `exe_im2, stay_sp, stay_src; instvalue=instin[6:0].
  0x00 `exe_break, stay, stay_src; 0x0B `exe_nop, stay, stay_src.
  0x02 `exe_pushsp, dec_sp, stay_src.
  0x04 `exe_poppc, inc_sp, inc_src.
  0x05/0x06/0x07 `exe_add/`exe_and/`exe_or, inc_sp, inc_src.
  0x08 `exe_load, stay, tos_src; 0x09 `exe_not, 0x0A `exe_flip, stay, stay_src.
  0x0C `exe_store, inc_sp, inc_src; 0x0D `exe_popsp, tos_sp, stay_src.
  0001xxxx `exe_addsp, stay, offset_src, instofset={1'b0,instin[3:0]}.
  010xxxxx storesp, inc_sp, inc_src, instofset=instin[4:0]^5'h10; offset 0 -> `exe_storesp1, 1 -> `exe_storesp2, else `exe_storesp.
  011xxxxx `exe_loadsp, dec_sp, offset_src, instofset=instin[4:0]^5'h10.
  0x23 `exe_storeh, 0x34 `exe_storeb: inc_sp, inc_src.
  0x37 `exe_eqbench, 0x38 `exe_neqbench: inc_sp, inc_src.
  other 001xxxxx `exe_emulate, dec_sp, stay_src, instofset=instin[4:0]; all other codes `exe_nop.
REQ-020 IM flag SHALL set on any accepted IM byte and clear on any accepted non-IM byte; instvalid=0 bubbles SHALL NOT clear it.
REQ-021 instofset and instvalue SHALL be 0 for opcodes not listed as driving them.
REQ-022 pcout/nextpcout/instructiondbgout SHALL update on every accepted cycle (stall=0, flush=0) including bubbles.

Reset
REQ-023 While rst=1: decodedinst=`exe_nop, spstate=`stay_sp, spstateadr=`stay_sp_source, instofset=0, instvalue=0, pcout=0, nextpcout=0, instructiondbgout=8'h01, IM flag=0, independent of clk.
REQ-024 Reset asserted mid-sequence SHALL clear IM flag so the next IM byte decodes as `exe_im.

Verification
REQ-025 instin 0x81,0x82,0x05 valid consecutive -> `exe_im(dec_sp, value 1), `exe_im2(stay, value 2), `exe_add(inc_sp, inc_src).
REQ-026 instin 0x81 then flush=1 then 0x83 -> nop then `exe_im (not `exe_im2), value 3.
REQ-027 instin 0x72 with stall=1 for 3 cycles -> outputs frozen at prior values; on release `exe_loadsp, instofset=5'h02, dec_sp, offset_src.
REQ-028 instin 0x50, 0x51, 0x55 -> `exe_storesp1 (ofs 0), `exe_storesp2 (ofs 1), `exe_storesp (ofs 5).
REQ-029 instin 0x37, pcin=0x100, nextpcin=0x101 -> `exe_eqbench, pcout=0x100, nextpcout=0x101, instructiondbgout=0x37.
REQ-030 rst pulsed asynchronously between clock edges -> all outputs at REQ-023 values before next edge.

Source files
------------

// File: rtl/decode_stage.sv
// ---------------------------------------------------------------------------
// decode_stage
//
// Purpose:
//   Decode stage of a ZPU pipeline. It takes one opcode byte per cycle from
//   fetch and registers:
//     - the execute operation code,
//     - the stack-pointer update action,
//     - the source of operand B,
//     - the stack-offset and immediate fields,
//     - the PCs that go with the byte.
//   Consecutive IM bytes are tracked so that each IM after the first one
//   decodes as the "shift and append" variant (exe_im2).
//
// Ports:
//   clk                clock; all state updates on its rising edge
//   rst                asynchronous active-high reset
//   stall              register-fetch stage cannot accept; hold everything
//   flush              redirect; the byte in flight becomes a nop
//                      (flush takes priority over stall)
//   instin[7:0]        opcode byte from fetch
//   instvalid          instin / pcin / nextpcin are valid this cycle
//   pcin, nextpcin     PC of instin and PC of the following byte
//   stallout           stall forwarded to fetch (combinational)
//   decodedinst[5:0]   execute operation code (exe_* below)
//   spstateadr[1:0]    operand-B source (*_sp_source below)
//   spstate[1:0]       stack-pointer update (*_sp below)
//   instofset[4:0]     stack-offset field
//   instvalue[6:0]     immediate field of IM
//   pcout, nextpcout   registered pcin / nextpcin
//   instructiondbgout  registered raw opcode byte, for debug
// ---------------------------------------------------------------------------
module decode_stage #(
    parameter int pc_bit_size = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   stall,
    input  logic                   flush,
    input  logic [7:0]             instin,
    input  logic                   instvalid,
    input  logic [pc_bit_size-1:0] pcin,
    input  logic [pc_bit_size-1:0] nextpcin,
    output logic                   stallout,
    output logic [5:0]             decodedinst,
    output logic [1:0]             spstateadr,
    output logic [1:0]             spstate,
    output logic [4:0]             instofset,
    output logic [6:0]             instvalue,
    output logic [pc_bit_size-1:0] pcout,
    output logic [pc_bit_size-1:0] nextpcout,
    output logic [7:0]             instructiondbgout
);

    // Execute operation codes
    localparam logic [5:0] exe_nop      = 6'd0;
    localparam logic [5:0] exe_im       = 6'd1;
    localparam logic [5:0] exe_im2      = 6'd2;
    localparam logic [5:0] exe_break    = 6'd3;
    localparam logic [5:0] exe_pushsp   = 6'd4;
    localparam logic [5:0] exe_poppc    = 6'd5;
    localparam logic [5:0] exe_add      = 6'd6;
    localparam logic [5:0] exe_and      = 6'd7;
    localparam logic [5:0] exe_or       = 6'd8;
    localparam logic [5:0] exe_load     = 6'd9;
    localparam logic [5:0] exe_not      = 6'd10;
    localparam logic [5:0] exe_flip     = 6'd11;
    localparam logic [5:0] exe_store    = 6'd12;
    localparam logic [5:0] exe_popsp    = 6'd13;
    localparam logic [5:0] exe_addsp    = 6'd14;
    localparam logic [5:0] exe_storesp  = 6'd15;
    localparam logic [5:0] exe_storesp1 = 6'd16;
    localparam logic [5:0] exe_storesp2 = 6'd17;
    localparam logic [5:0] exe_loadsp   = 6'd18;
    localparam logic [5:0] exe_storeh   = 6'd19;
    localparam logic [5:0] exe_storeb   = 6'd20;
    localparam logic [5:0] exe_eqbench  = 6'd21;
    localparam logic [5:0] exe_neqbench = 6'd22;
    localparam logic [5:0] exe_emulate  = 6'd23;

    // Stack-pointer update actions
    localparam logic [1:0] stay_sp = 2'd0;
    localparam logic [1:0] inc_sp  = 2'd1;
    localparam logic [1:0] dec_sp  = 2'd2;
    localparam logic [1:0] tos_sp  = 2'd3;

    // Operand-B source selections
    localparam logic [1:0] stay_sp_source   = 2'd0;
    localparam logic [1:0] inc_sp_source    = 2'd1;
    localparam logic [1:0] offset_sp_source = 2'd2;
    localparam logic [1:0] tos_sp_source    = 2'd3;

    // Set while the most recently accepted byte was an IM.
    logic       im_flag;

    logic [5:0] dec_inst;
    logic [1:0] dec_sp_state;
    logic [1:0] dec_sp_src;
    logic [4:0] dec_ofs;
    logic [6:0] dec_val;
    logic       dec_is_im;

    // storesp/loadsp encode the offset with bit 4 inverted
    logic [4:0] sp_ofs;

    assign stallout = stall;
    assign sp_ofs   = instin[4:0] ^ 5'h10;

    // Opcode decode. This is purely a function of the byte and the IM flag.
    // Whether the result is used is decided in the register block.
    always_comb begin
        dec_inst     = exe_nop;
        dec_sp_state = stay_sp;
        dec_sp_src   = stay_sp_source;
        dec_ofs      = 5'd0;
        dec_val      = 7'd0;
        dec_is_im    = 1'b0;

        if (instin[7]) begin
            // The first IM of a run pushes a new word; later ones append into it.
            dec_is_im = 1'b1;
            dec_val   = instin[6:0];
            if (im_flag) begin
                dec_inst     = exe_im2;
                dec_sp_state = stay_sp;
            end else begin
                dec_inst     = exe_im;
                dec_sp_state = dec_sp;
            end
        end else if (instin[6:5] == 2'b10) begin
            dec_sp_state = inc_sp;
            dec_sp_src   = inc_sp_source;
            dec_ofs      = sp_ofs;
            if (sp_ofs == 5'd0) begin
                dec_inst = exe_storesp1;
            end else if (sp_ofs == 5'd1) begin
                dec_inst = exe_storesp2;
            end else begin
                dec_inst = exe_storesp;
            end
        end else if (instin[6:5] == 2'b11) begin
            dec_inst     = exe_loadsp;
            dec_sp_state = dec_sp;
            dec_sp_src   = offset_sp_source;
            dec_ofs      = sp_ofs;
        end else if (instin[6:5] == 2'b01) begin
            // Some of these are real ops. The rest trap to the emulation vector.
            case (instin)
                8'h23: begin
                    dec_inst     = exe_storeh;
                    dec_sp_state = inc_sp;
                    dec_sp_src   = inc_sp_source;
                end
                8'h34: begin
                    dec_inst     = exe_storeb;
                    dec_sp_state = inc_sp;
                    dec_sp_src   = inc_sp_source;
                end
                8'h37: begin
                    dec_inst     = exe_eqbench;
                    dec_sp_state = inc_sp;
                    dec_sp_src   = inc_sp_source;
                end
                8'h38: begin
                    dec_inst     = exe_neqbench;
                    dec_sp_state = inc_sp;
                    dec_sp_src   = inc_sp_source;
                end
                default: begin
                    dec_inst     = exe_emulate;
                    dec_sp_state = dec_sp;
                    dec_ofs      = instin[4:0];
                end
            endcase
        end else if (instin[4]) begin
            dec_inst   = exe_addsp;
            dec_sp_src = offset_sp_source;
            dec_ofs    = {1'b0, instin[3:0]};
        end else begin
            case (instin[3:0])
                4'h0: dec_inst = exe_break;
                4'h2: begin
                    dec_inst     = exe_pushsp;
                    dec_sp_state = dec_sp;
                end
                4'h4: begin
                    dec_inst     = exe_poppc;
                    dec_sp_state = inc_sp;
                    dec_sp_src   = inc_sp_source;
                end
                4'h5: begin
                    dec_inst     = exe_add;
                    dec_sp_state = inc_sp;
                    dec_sp_src   = inc_sp_source;
                end
                4'h6: begin
                    dec_inst     = exe_and;
                    dec_sp_state = inc_sp;
                    dec_sp_src   = inc_sp_source;
                end
                4'h7: begin
                    dec_inst     = exe_or;
                    dec_sp_state = inc_sp;
                    dec_sp_src   = inc_sp_source;
                end
                4'h8: begin
                    dec_inst   = exe_load;
                    dec_sp_src = tos_sp_source;
                end
                4'h9: dec_inst = exe_not;
                4'hA: dec_inst = exe_flip;
                4'hB: dec_inst = exe_nop;
                4'hC: begin
                    dec_inst     = exe_store;
                    dec_sp_state = inc_sp;
                    dec_sp_src   = inc_sp_source;
                end
                4'hD: begin
                    dec_inst     = exe_popsp;
                    dec_sp_state = tos_sp;
                end
                default: dec_inst = exe_nop;
            endcase
        end
    end

    // Pipeline register. flush beats stall, and stall freezes everything.
    // A bubble turns into a nop. It leaves the IM flag alone, so an IM run
    // split by a fetch gap is still treated as one run. The PC and debug
    // registers follow their inputs on every accepted cycle, bubbles included.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            decodedinst       <= exe_nop;
            spstate           <= stay_sp;
            spstateadr        <= stay_sp_source;
            instofset         <= 5'd0;
            instvalue         <= 7'd0;
            pcout             <= '0;
            nextpcout         <= '0;
            instructiondbgout <= 8'h01;
            im_flag           <= 1'b0;
        end else if (flush) begin
            decodedinst <= exe_nop;
            spstate     <= stay_sp;
            spstateadr  <= stay_sp_source;
            im_flag     <= 1'b0;
        end else if (!stall) begin
            pcout             <= pcin;
            nextpcout         <= nextpcin;
            instructiondbgout <= instin;
            if (instvalid) begin
                decodedinst <= dec_inst;
                spstate     <= dec_sp_state;
                spstateadr  <= dec_sp_src;
                instofset   <= dec_ofs;
                instvalue   <= dec_val;
                im_flag     <= dec_is_im;
            end else begin
                decodedinst <= exe_nop;
                spstate     <= stay_sp;
                spstateadr  <= stay_sp_source;
                instofset   <= 5'd0;
                instvalue   <= 7'd0;
            end
        end
    end

endmodule

// File: tb/tb_decode_stage.sv
// ---------------------------------------------------------------------------
// tb_decode_stage
//
// Purpose:
//   Directed, self-checking bench for decode_stage. It applies a linear
//   sequence of hand-written opcode bytes. After each clock edge it compares
//   the registered outputs against hand-computed expected values.
//
// Ports: none (top-level bench).
// ---------------------------------------------------------------------------
module tb_decode_stage;

    // Expected encodings, written out independently of the design
    localparam logic [5:0] NOP = 6'd0,  IM = 6'd1,  IM2 = 6'd2;
    localparam logic [5:0] ADD = 6'd6,  LOAD = 6'd9, POPSP = 6'd13, ADDSP = 6'd14;
    localparam logic [5:0] STORESP = 6'd15, STORESP1 = 6'd16, STORESP2 = 6'd17;
    localparam logic [5:0] LOADSP = 6'd18, EQBENCH = 6'd21, EMULATE = 6'd23;
    localparam logic [1:0] S_STAY = 2'd0, S_INC = 2'd1, S_DEC = 2'd2, S_TOS = 2'd3;
    localparam logic [1:0] A_STAY = 2'd0, A_INC = 2'd1, A_OFS = 2'd2, A_TOS = 2'd3;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        flush;
    logic [7:0]  instin;
    logic        instvalid;
    logic [31:0] pcin;
    logic [31:0] nextpcin;
    logic        stallout;
    logic [5:0]  decodedinst;
    logic [1:0]  spstateadr;
    logic [1:0]  spstate;
    logic [4:0]  instofset;
    logic [6:0]  instvalue;
    logic [31:0] pcout;
    logic [31:0] nextpcout;
    logic [7:0]  instructiondbgout;

    int pass_count = 0;
    int check_count = 0;

    decode_stage #(.pc_bit_size(32)) dut (
        .clk               (clk),
        .rst               (rst),
        .stall             (stall),
        .flush             (flush),
        .instin            (instin),
        .instvalid         (instvalid),
        .pcin              (pcin),
        .nextpcin          (nextpcin),
        .stallout          (stallout),
        .decodedinst       (decodedinst),
        .spstateadr        (spstateadr),
        .spstate           (spstate),
        .instofset         (instofset),
        .instvalue         (instvalue),
        .pcout             (pcout),
        .nextpcout         (nextpcout),
        .instructiondbgout (instructiondbgout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one cycle of inputs, then sample 1 time unit after the rising edge
    task automatic apply_stimulus(input logic [7:0] inst, input logic valid,
                                  input logic stl, input logic fl,
                                  input logic [31:0] pc);
        instin    = inst;
        instvalid = valid;
        stall     = stl;
        flush     = fl;
        pcin      = pc;
        nextpcin  = pc + 32'd1;
        @(posedge clk);
        #1;
    endtask

    task automatic check_output(input string tag, input logic [31:0] observed,
                                input logic [31:0] expected);
        check_count++;
        assert (observed === expected) pass_count++;
        else $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    endtask

    // Decode triple plus the two fields
    task automatic check_decode(input string tag, input logic [5:0] inst,
                                input logic [1:0] sps, input logic [1:0] spa,
                                input logic [4:0] ofs, input logic [6:0] val);
        check_output({tag, ".inst"}, 32'(decodedinst), 32'(inst));
        check_output({tag, ".sp"},   32'(spstate),     32'(sps));
        check_output({tag, ".src"},  32'(spstateadr),  32'(spa));
        check_output({tag, ".ofs"},  32'(instofset),   32'(ofs));
        check_output({tag, ".val"},  32'(instvalue),   32'(val));
    endtask

    task automatic check_reset_state(input string tag);
        check_decode(tag, NOP, S_STAY, A_STAY, 5'd0, 7'd0);
        check_output({tag, ".pc"},   pcout,                     32'h0);
        check_output({tag, ".npc"},  nextpcout,                 32'h0);
        check_output({tag, ".dbg"},  32'(instructiondbgout),    32'h01);
    endtask

    initial begin
        rst       = 1'b1;
        stall     = 1'b0;
        flush     = 1'b0;
        instin    = 8'h00;
        instvalid = 1'b0;
        pcin      = 32'h0;
        nextpcin  = 32'h0;

        // Reset values before any clock edge
        #2;
        check_reset_state("reset");
        stall = 1'b1;
        #1;
        check_output("stallout_hi", 32'(stallout), 32'd1);
        stall = 1'b0;
        #1;
        check_output("stallout_lo", 32'(stallout), 32'd0);
        #4;
        rst = 1'b0;

        // IM run followed by add
        apply_stimulus(8'h81, 1'b1, 1'b0, 1'b0, 32'h10);
        check_decode("im1", IM, S_DEC, A_STAY, 5'd0, 7'd1);
        apply_stimulus(8'h82, 1'b1, 1'b0, 1'b0, 32'h11);
        check_decode("im2", IM2, S_STAY, A_STAY, 5'd0, 7'd2);
        apply_stimulus(8'h05, 1'b1, 1'b0, 1'b0, 32'h12);
        check_decode("add", ADD, S_INC, A_INC, 5'd0, 7'd0);
        check_output("add.pc", pcout, 32'h12);

        // Flush breaks an IM run and holds the non-decode outputs
        apply_stimulus(8'h81, 1'b1, 1'b0, 1'b0, 32'h20);
        check_decode("fl_im", IM, S_DEC, A_STAY, 5'd0, 7'd1);
        apply_stimulus(8'h90, 1'b1, 1'b1, 1'b1, 32'h21);
        check_decode("flush", NOP, S_STAY, A_STAY, 5'd0, 7'd1);
        check_output("flush.pc", pcout, 32'h20);
        check_output("flush.dbg", 32'(instructiondbgout), 32'h81);
        apply_stimulus(8'h83, 1'b1, 1'b0, 1'b0, 32'h22);
        check_decode("after_flush", IM, S_DEC, A_STAY, 5'd0, 7'd3);

        // Stall holds for three cycles, then loadsp
        for (int i = 0; i < 3; i++) begin
            apply_stimulus(8'h72, 1'b1, 1'b1, 1'b0, 32'h30);
            check_output("stall.inst", 32'(decodedinst), 32'(IM));
            check_output("stall.val", 32'(instvalue), 32'd3);
            check_output("stall.pc", pcout, 32'h22);
            check_output("stall.out", 32'(stallout), 32'd1);
        end
        apply_stimulus(8'h72, 1'b1, 1'b0, 1'b0, 32'h30);
        check_decode("loadsp", LOADSP, S_DEC, A_OFS, 5'h02, 7'd0);

        // storesp offset variants
        apply_stimulus(8'h50, 1'b1, 1'b0, 1'b0, 32'h40);
        check_decode("storesp1", STORESP1, S_INC, A_INC, 5'd0, 7'd0);
        apply_stimulus(8'h51, 1'b1, 1'b0, 1'b0, 32'h41);
        check_decode("storesp2", STORESP2, S_INC, A_INC, 5'd1, 7'd0);
        apply_stimulus(8'h55, 1'b1, 1'b0, 1'b0, 32'h42);
        check_decode("storesp", STORESP, S_INC, A_INC, 5'd5, 7'd0);

        // eqbench with PC passthrough
        apply_stimulus(8'h37, 1'b1, 1'b0, 1'b0, 32'h100);
        check_decode("eqbench", EQBENCH, S_INC, A_INC, 5'd0, 7'd0);
        check_output("eq.pc", pcout, 32'h100);
        check_output("eq.npc", nextpcout, 32'h101);
        check_output("eq.dbg", 32'(instructiondbgout), 32'h37);

        // Other decode groups
        apply_stimulus(8'h1A, 1'b1, 1'b0, 1'b0, 32'h50);
        check_decode("addsp", ADDSP, S_STAY, A_OFS, 5'h0A, 7'd0);
        apply_stimulus(8'h2B, 1'b1, 1'b0, 1'b0, 32'h51);
        check_decode("emulate", EMULATE, S_DEC, A_STAY, 5'h0B, 7'd0);
        apply_stimulus(8'h0D, 1'b1, 1'b0, 1'b0, 32'h52);
        check_decode("popsp", POPSP, S_TOS, A_STAY, 5'd0, 7'd0);
        apply_stimulus(8'h08, 1'b1, 1'b0, 1'b0, 32'h53);
        check_decode("load", LOAD, S_STAY, A_TOS, 5'd0, 7'd0);
        apply_stimulus(8'h0E, 1'b1, 1'b0, 1'b0, 32'h54);
        check_decode("undef", NOP, S_STAY, A_STAY, 5'd0, 7'd0);

        // A bubble between IM bytes keeps the IM run alive
        apply_stimulus(8'h81, 1'b1, 1'b0, 1'b0, 32'h60);
        check_decode("bub_im", IM, S_DEC, A_STAY, 5'd0, 7'd1);
        apply_stimulus(8'h00, 1'b0, 1'b0, 1'b0, 32'h200);
        check_output("bubble.inst", 32'(decodedinst), 32'(NOP));
        check_output("bubble.sp", 32'(spstate), 32'(S_STAY));
        check_output("bubble.pc", pcout, 32'h200);
        check_output("bubble.npc", nextpcout, 32'h201);
        apply_stimulus(8'h82, 1'b1, 1'b0, 1'b0, 32'h61);
        check_decode("bub_im2", IM2, S_STAY, A_STAY, 5'd0, 7'd2);

        // Asynchronous reset between edges clears outputs and the IM run
        #2;
        rst = 1'b1;
        #1;
        check_reset_state("async_rst");
        #1;
        rst = 1'b0;
        apply_stimulus(8'h85, 1'b1, 1'b0, 1'b0, 32'h70);
        check_decode("rst_im", IM, S_DEC, A_STAY, 5'd0, 7'd5);

        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule
